// File: rtl/mem_request_generator.sv
// Strided memory request generator: walks a descriptor [index_start, index_end) and
// emits one byte-offset request per cycle, with backpressure and carry-safe termination.
module mem_request_generator #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INDEX_WIDTH = 32,
  parameter int ID_WIDTH    = 1
) (
  input  logic                   ap_clk,
  input  logic                   areset,
  input  logic                   start_in,
  input  logic [ADDR_WIDTH-1:0]  base_address_in,
  input  logic [INDEX_WIDTH-1:0] index_start_in,
  input  logic [INDEX_WIDTH-1:0] index_end_in,
  input  logic [INDEX_WIDTH-1:0] stride_in,
  input  logic [3:0]             shift_in,
  input  logic [ID_WIDTH-1:0]    id_in,
  input  logic                   pause_in,
  output logic                   mem_req_valid_out,
  output logic [ADDR_WIDTH-1:0]  mem_req_base_address_out,
  output logic [ADDR_WIDTH-1:0]  mem_req_address_offset_out,
  output logic [ID_WIDTH-1:0]    mem_req_id_out,
  output logic                   busy_out,
  output logic                   done_out,
  output logic [INDEX_WIDTH-1:0] req_count_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_BUSY,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_base;
  logic [ADDR_WIDTH-1:0]  r_offset;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [INDEX_WIDTH-1:0] r_end;
  logic [INDEX_WIDTH-1:0] r_stride;
  logic [INDEX_WIDTH-1:0] r_count;
  logic [3:0]             r_shift;
  logic [ID_WIDTH-1:0]    r_id;
  logic                   r_last;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_done;

  logic [INDEX_WIDTH:0]   w_sum;
  logic                   w_last;
  logic                   w_empty;
  logic                   w_issue;
  logic [ADDR_WIDTH-1:0]  w_offset;

  // The extra sum bit catches a carry out, so a near-max index never wraps into a bogus request.
  assign w_sum    = {1'b0, r_index} + {1'b0, r_stride};
  assign w_last   = w_sum[INDEX_WIDTH] | (w_sum >= {1'b0, r_end});
  assign w_empty  = (r_index >= r_end);
  assign w_offset = ADDR_WIDTH'(r_index) << r_shift;

  // A request is registered on the edge that enters (or stays in) BUSY, so valid coincides
  // with BUSY and DONE follows the last valid cycle.
  assign w_issue = !pause_in &&
                   (((r_state == S_SETUP) && !w_empty) ||
                    ((r_state == S_BUSY)  && !r_last)  ||
                     (r_state == S_PAUSE));

  // NOTE: every register here is state, so all updates are non-blocking; the asynchronous
  // reset clears every output register so the outputs go to zero without waiting for a clock.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_offset <= '0;
      r_index  <= '0;
      r_end    <= '0;
      r_stride <= '0;
      r_count  <= '0;
      r_shift  <= '0;
      r_id     <= '0;
      r_last   <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_valid <= w_issue;
      if (w_issue) begin
        r_offset <= w_offset;
        r_index  <= w_sum[INDEX_WIDTH-1:0];
        r_count  <= r_count + INDEX_WIDTH'(1);
        r_last   <= w_last;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_in) begin
            r_base   <= base_address_in;
            r_index  <= index_start_in;
            r_end    <= index_end_in;
            r_stride <= (stride_in == '0) ? INDEX_WIDTH'(1) : stride_in;
            r_shift  <= shift_in;
            r_id     <= id_in;
            r_count  <= '0;
            r_last   <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_empty) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (pause_in) begin
            r_state <= S_PAUSE;
          end else begin
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (pause_in) begin
            r_state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (!pause_in) begin
            r_state <= S_BUSY;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req_valid_out          = r_valid;
  assign mem_req_base_address_out   = r_base;
  assign mem_req_address_offset_out = r_offset;
  assign mem_req_id_out             = r_id;
  assign busy_out                   = r_busy;
  assign done_out                   = r_done;
  assign req_count_out              = r_count;

endmodule

// File: tb/tb_mem_request_generator.sv
// Directed bench for mem_request_generator: a descriptor table walked in a loop, plus
// hand-written reset and start-while-busy sequences.
module tb_mem_request_generator;

  logic        ap_clk;
  logic        areset;
  logic        start_in;
  logic [63:0] base_address_in;
  logic [31:0] index_start_in;
  logic [31:0] index_end_in;
  logic [31:0] stride_in;
  logic [3:0]  shift_in;
  logic [0:0]  id_in;
  logic        pause_in;
  logic        mem_req_valid_out;
  logic [63:0] mem_req_base_address_out;
  logic [63:0] mem_req_address_offset_out;
  logic [0:0]  mem_req_id_out;
  logic        busy_out;
  logic        done_out;
  logic [31:0] req_count_out;

  int n_vectors = 0;
  int n_miscompares = 0;
  logic last_pause = 1'b0;

  mem_request_generator #(.ADDR_WIDTH(64), .INDEX_WIDTH(32), .ID_WIDTH(1)) dut (
    .ap_clk                     (ap_clk),
    .areset                     (areset),
    .start_in                   (start_in),
    .base_address_in            (base_address_in),
    .index_start_in             (index_start_in),
    .index_end_in               (index_end_in),
    .stride_in                  (stride_in),
    .shift_in                   (shift_in),
    .id_in                      (id_in),
    .pause_in                   (pause_in),
    .mem_req_valid_out          (mem_req_valid_out),
    .mem_req_base_address_out   (mem_req_base_address_out),
    .mem_req_address_offset_out (mem_req_address_offset_out),
    .mem_req_id_out             (mem_req_id_out),
    .busy_out                   (busy_out),
    .done_out                   (done_out),
    .req_count_out              (req_count_out)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) last_pause <= pause_in;

  typedef struct {
    logic [63:0] base;
    logic [31:0] istart;
    logic [31:0] iend;
    logic [31:0] stride;
    logic [3:0]  shift;
    logic [0:0]  id;
    logic [63:0] first_off;
    logic [63:0] step;
    int          exp_count;
    int          exp_first;
    int          exp_done;
    int          pause_at;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},  64'(mem_req_valid_out), 64'd0);
    check({tag, "_busy"},   64'(busy_out), 64'd0);
    check({tag, "_done"},   64'(done_out), 64'd0);
    check({tag, "_count"},  64'(req_count_out), 64'd0);
    check({tag, "_base"},   mem_req_base_address_out, 64'd0);
    check({tag, "_offset"}, mem_req_address_offset_out, 64'd0);
    check({tag, "_id"},     64'(mem_req_id_out), 64'd0);
  endtask

  task automatic set_desc(input logic [63:0] base, input logic [31:0] s, input logic [31:0] e,
                          input logic [31:0] st, input logic [3:0] sh, input logic [0:0] id);
    base_address_in = base;
    index_start_in  = s;
    index_end_in    = e;
    stride_in       = st;
    shift_in        = sh;
    id_in           = id;
  endtask

  // Cycle 0 is the cycle with start_in high; cycle c is observed at the negedge inside it.
  task automatic run_vec(input int n, input vec_t v);
    int k = 0;
    int first_v = -1;
    int done_c = -1;
    int busy_n = 0;
    logic [63:0] exp_off;
    next_cycle();
    set_desc(v.base, v.istart, v.iend, v.stride, v.shift, v.id);
    start_in = 1'b1;
    next_cycle();
    start_in = 1'b0;
    for (int c = 1; c <= 60 && done_c < 0; c++) begin
      if (v.pause_at != 0) pause_in = (c >= v.pause_at) && (c < v.pause_at + 3);
      @(negedge ap_clk);
      if (c == 1) check($sformatf("v%0d_done_falls", n), 64'(done_out), 64'd0);
      if (last_pause) check($sformatf("v%0d_no_valid_paused_c%0d", n, c), 64'(mem_req_valid_out), 64'd0);
      if (busy_out) busy_n++;
      if (mem_req_valid_out) begin
        if (first_v < 0) first_v = c;
        exp_off = v.first_off + 64'(k) * v.step;
        check($sformatf("v%0d_offset%0d", n, k), mem_req_address_offset_out, exp_off);
        check($sformatf("v%0d_base%0d", n, k), mem_req_base_address_out, v.base);
        check($sformatf("v%0d_id%0d", n, k), 64'(mem_req_id_out), 64'(v.id));
        k++;
      end
      if (done_out) done_c = c;
      if (c < 60 && done_c < 0) next_cycle();
    end
    pause_in = 1'b0;
    check($sformatf("v%0d_num_valid", n), 64'(k), 64'(v.exp_count));
    check($sformatf("v%0d_req_count", n), 64'(req_count_out), 64'(v.exp_count));
    check($sformatf("v%0d_first_valid_cycle", n), 64'(first_v), 64'(v.exp_first));
    check($sformatf("v%0d_done_cycle", n), 64'(done_c), 64'(v.exp_done));
    check($sformatf("v%0d_busy_cycles", n), 64'(busy_n), 64'(v.exp_done - 1));
  endtask

  initial begin
    // base, start, end, stride, shift, id, first_off, step, count, first_valid, done, pause_at
    vecs[0] = '{64'h1000, 32'd0, 32'd4, 32'd1, 4'd2, 1'b1, 64'h0, 64'h4, 4, 2, 6, 0};
    vecs[1] = '{64'h2000, 32'd5, 32'd5, 32'd1, 4'd2, 1'b0, 64'h0, 64'h0, 0, -1, 2, 0};
    vecs[2] = '{64'h3000, 32'd0, 32'd8, 32'd3, 4'd3, 1'b1, 64'h0, 64'h18, 3, 2, 5, 0};
    vecs[3] = '{64'h4000, 32'd0, 32'd2, 32'd0, 4'd3, 1'b0, 64'h0, 64'h8, 2, 2, 4, 0};
    vecs[4] = '{64'hAB00, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd4, 4'd0, 1'b1,
                64'hFFFF_FFFE, 64'h0, 1, 2, 3, 0};
    vecs[5] = '{64'h6000, 32'd0, 32'd6, 32'd1, 4'd2, 1'b1, 64'h0, 64'h4, 6, 2, 11, 3};
    vecs[6] = '{64'h7000, 32'd9, 32'd3, 32'd1, 4'd1, 1'b0, 64'h0, 64'h0, 0, -1, 2, 0};

    areset   = 1'b0;
    start_in = 1'b0;
    pause_in = 1'b0;
    set_desc(64'h0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    #1 areset = 1'b1;
    #2 check_zero("reset_async");
    next_cycle();
    next_cycle();
    areset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Start pulse while BUSY must be ignored, then reset mid-stream.
    next_cycle();
    set_desc(64'h5000, 32'd0, 32'd100, 32'd1, 4'd2, 1'b0);
    start_in = 1'b1;
    next_cycle();
    start_in = 1'b0;
    next_cycle();
    next_cycle();
    set_desc(64'hDEAD_0000, 32'd50, 32'd60, 32'd7, 4'd0, 1'b1);
    start_in = 1'b1;
    next_cycle();
    start_in = 1'b0;
    @(negedge ap_clk);
    check("busy_start_valid_c4",  64'(mem_req_valid_out), 64'd1);
    check("busy_start_base_c4",   mem_req_base_address_out, 64'h5000);
    check("busy_start_offset_c4", mem_req_address_offset_out, 64'h8);
    check("busy_start_id_c4",     64'(mem_req_id_out), 64'd0);
    next_cycle();
    @(negedge ap_clk);
    check("busy_start_offset_c5", mem_req_address_offset_out, 64'hC);
    check("busy_start_count_c5",  64'(req_count_out), 64'd4);
    check("busy_start_busy_c5",   64'(busy_out), 64'd1);
    next_cycle();
    #2 areset = 1'b1;
    #1 check_zero("reset_mid_busy");
    next_cycle();
    next_cycle();
    areset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge ap_clk);
      check($sformatf("post_reset_valid_c%0d", c), 64'(mem_req_valid_out), 64'd0);
      check($sformatf("post_reset_busy_c%0d", c), 64'(busy_out), 64'd0);
      check($sformatf("post_reset_done_c%0d", c), 64'(done_out), 64'd0);
      next_cycle();
    end

    run_vec(7, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
